mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 166 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32x32 multiply / divide unit with HI/LO registers.
// Optional DivZero output is enabled by defining MDU_DIVZERO_FLAG_EN.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MulStart,
    input  logic        MulSelMD,
    input  logic        Sign,
    input  logic        MulSelHL,
    input  logic        MulWrite,
`ifdef MDU_DIVZERO_FLAG_EN
    output logic        DivZero,
`endif
    output logic        mulready,
    output logic [31:0] HLOut
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic        r_sa;
    logic        r_sb;
    logic        r_md;
    logic        r_bz;

    logic        w_start;
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_amag;
    logic [31:0] w_bmag;
    logic [32:0] w_madd;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [63:0] w_step;
    logic        w_neg;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_hi_fix;
    logic [31:0] w_lo_fix;

    assign w_start  = (r_state == S_IDLE) && MulStart;
    assign w_sa     = Sign & A[31];
    assign w_sb     = Sign & B[31];
    assign w_amag   = w_sa ? (32'd0 - A) : A;
    assign w_bmag   = w_sb ? (32'd0 - B) : B;

    // Shift-add: add multiplicand into the upper half, then shift right.
    assign w_madd   = {1'b0, r_acc[63:32]}
                    + {1'b0, (r_acc[0] ? r_a : 32'd0)};

    // Restoring divide: partial remainder shifted left by one dividend bit.
    assign w_ge     = r_acc[63:31] >= {1'b0, r_b};
    assign w_diff   = r_acc[62:31] - r_b;

    assign w_step   = r_md
                    ? (w_ge ? {w_diff, r_acc[30:0], 1'b1}
                            : {r_acc[62:0], 1'b0})
                    : {w_madd, r_acc[31:1]};

    // Sign correction applied in FIX; divide by zero forces an all-ones quotient.
    assign w_neg    = r_sa ^ r_sb;
    assign w_prod   = w_neg ? (64'd0 - r_acc) : r_acc;
    assign w_quo    = r_bz ? 32'hFFFF_FFFF
                    : (w_neg ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
    assign w_rem    = r_sa ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    assign w_hi_fix = r_md ? w_rem : w_prod[63:32];
    assign w_lo_fix = r_md ? w_quo : w_prod[31:0];

    assign mulready = (r_state == S_IDLE);
    assign HLOut    = MulSelHL ? r_hi : r_lo;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: 32 CALC cycles then one FIX cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (MulStart) w_next = S_CALC;
            S_CALC: if (r_cnt == 6'd31) w_next = S_FIX;
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and HI/LO update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 6'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_acc <= 64'd0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_md  <= 1'b0;
            r_bz  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (MulStart) begin
                        r_cnt <= 6'd0;
                        r_sa  <= w_sa;
                        r_sb  <= w_sb;
                        r_md  <= MulSelMD;
                        r_bz  <= (B == 32'd0);
                        r_a   <= w_amag;
                        r_b   <= w_bmag;
                        r_acc <= MulSelMD ? {32'd0, w_amag}
                                          : {32'd0, w_bmag};
                    end else if (MulWrite) begin
                        if (MulSelHL) r_hi <= A;
                        else          r_lo <= A;
                    end
                end
                S_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_FIX: begin
                    r_hi <= w_hi_fix;
                    r_lo <= w_lo_fix;
                end
                default: ;
            endcase
        end
    end

`ifdef MDU_DIVZERO_FLAG_EN
    logic r_dz;
    assign DivZero = r_dz;

    // Sticky divide-by-zero flag, cleared when a new operation starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dz <= 1'b0;
        end else if (w_start) begin
            r_dz <= 1'b0;
        end else if (r_state == S_FIX && r_md && r_bz) begin
            r_dz <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit.
// Driver pushes expected HI/LO per operation; monitor checks on completion.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        MulStart;
    logic        MulSelMD;
    logic        Sign;
    logic        MulSelHL;
    logic        MulWrite;
    logic        mulready;
    logic [31:0] HLOut;
`ifdef MDU_DIVZERO_FLAG_EN
    logic        DivZero;
`endif

    logic drv_sel;
    logic mon_own;
    logic mon_sel;
    assign MulSelHL = mon_own ? mon_sel : drv_sel;

    mul_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .MulStart (MulStart),
        .MulSelMD (MulSelMD),
        .Sign     (Sign),
        .MulSelHL (MulSelHL),
        .MulWrite (MulWrite),
`ifdef MDU_DIVZERO_FLAG_EN
        .DivZero  (DivZero),
`endif
        .mulready (mulready),
        .HLOut    (HLOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    // Monitor: on each completion, read LO then HI and compare.
    initial begin : monitor
        logic prev;
        exp_t e;
        mon_own = 1'b0;
        mon_sel = 1'b0;
        prev    = 1'b1;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && prev === 1'b0 && mulready === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected completion", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    mon_own = 1'b1;
                    mon_sel = 1'b0;
                    #1 chk({e.nm, " LO"}, HLOut, e.lo);
                    mon_sel = 1'b1;
                    #1 chk({e.nm, " HI"}, HLOut, e.hi);
                    mon_own = 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
                    chk({e.nm, " DivZero"}, {31'd0, DivZero}, {31'd0, e.dz});
`endif
                end
            end
            prev = mulready;
        end
    end

    task automatic run_op(input string nm, input logic [31:0] a,
                          input logic [31:0] b, input logic md,
                          input logic sg, input logic wr, input logic inj,
                          input logic [31:0] hi, input logic [31:0] lo,
                          input logic dz);
        exp_t e;
        int   busy;
        e.nm = nm; e.hi = hi; e.lo = lo; e.dz = dz;
        sb.push_back(e);
        @(negedge clk);
        A = a; B = b; MulSelMD = md; Sign = sg;
        drv_sel = 1'b1; MulWrite = wr; MulStart = 1'b1;
        @(negedge clk);
        MulStart = 1'b0; MulWrite = 1'b0;
        busy = 0;
        while (mulready !== 1'b1 && busy < 100) begin
            busy++;
            if (busy == 5) chk({nm, " HI during busy"}, HLOut, m_hi);
`ifdef MDU_DIVZERO_FLAG_EN
            if (busy == 2) chk({nm, " DivZero cleared"},
                               {31'd0, DivZero}, 32'd0);
`endif
            if (busy == 3) begin A = ~a; B = ~b; end
            if (inj && busy == 10) begin
                A = 32'hDEADBEEF; B = 32'd3;
                MulStart = 1'b1; MulWrite = 1'b1;
            end
            if (inj && busy == 11) begin
                MulStart = 1'b0; MulWrite = 1'b0;
            end
            @(negedge clk);
        end
        chk({nm, " busy cycles"}, busy, 32'd33);
        m_hi = hi; m_lo = lo;
    endtask

    task automatic mt(input logic sel, input logic [31:0] v);
        @(negedge clk);
        drv_sel = sel; A = v; MulWrite = 1'b1;
        @(negedge clk);
        MulWrite = 1'b0;
        if (sel) m_hi = v; else m_lo = v;
        #3 drv_sel = 1'b1;
        #1 chk("MT read HI", HLOut, m_hi);
        drv_sel = 1'b0;
        #1 chk("MT read LO", HLOut, m_lo);
    endtask

    initial begin : driver
        int n;
        reset = 1'b0; A = '0; B = '0; MulStart = 1'b0; MulSelMD = 1'b0;
        Sign = 1'b0; MulWrite = 1'b0; drv_sel = 1'b0;
        repeat (2) @(negedge clk);
        #3 chk("reset mulready", {31'd0, mulready}, 32'd1);
        #1 chk("reset LO", HLOut, 32'd0);
        drv_sel = 1'b1;
        #1 chk("reset HI", HLOut, 32'd0);
        @(negedge clk); #3 reset = 1'b1;

        run_op("umul", 32'hFFFFFFFF, 32'd2, 0, 0, 0, 0,
               32'd1, 32'hFFFFFFFE, 0);
        run_op("smul", 32'hFFFFFFF9, 32'd3, 0, 1, 0, 0,
               32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_op("smul min", 32'h80000000, 32'h80000000, 0, 1, 0, 0,
               32'h40000000, 32'd0, 0);
        run_op("umul max", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0,
               32'hFFFFFFFE, 32'd1, 0);
        run_op("sdiv", 32'hFFFFFFF9, 32'd2, 1, 1, 0, 0,
               32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("sdiv0", 32'h12345678, 32'd0, 1, 1, 0, 0,
               32'h12345678, 32'hFFFFFFFF, 1);
        run_op("sdiv0 neg", 32'hFFFFFFF9, 32'd0, 1, 1, 0, 0,
               32'hFFFFFFF9, 32'hFFFFFFFF, 1);
        run_op("udiv0", 32'h80000001, 32'd0, 1, 0, 0, 0,
               32'h80000001, 32'hFFFFFFFF, 1);
        run_op("sdiv ovf", 32'h80000000, 32'hFFFFFFFF, 1, 1, 0, 0,
               32'd0, 32'h80000000, 0);
        run_op("udiv", 32'hFFFFFFFF, 32'd10, 1, 0, 0, 0,
               32'd5, 32'h19999999, 0);
        run_op("sdiv negb", 32'd7, 32'hFFFFFFFE, 1, 1, 0, 0,
               32'd1, 32'hFFFFFFFD, 0);

        mt(1'b1, 32'hCAFEF00D);
        mt(1'b0, 32'h11111111);

        run_op("busy protect", 32'h00010000, 32'h00010000, 0, 0, 0, 1,
               32'd1, 32'd0, 0);
        run_op("start beats write", 32'd6, 32'd7, 0, 0, 1, 0,
               32'd0, 32'd42, 0);

        @(negedge clk);
        A = 32'd9; B = 32'd9; MulSelMD = 1'b0; Sign = 1'b0;
        MulStart = 1'b1;
        @(negedge clk);
        MulStart = 1'b0;
        n = 1;
        while (n < 15) begin
            @(negedge clk);
            n++;
        end
        #3 reset = 1'b0;
        #1 chk("abort mulready", {31'd0, mulready}, 32'd1);
        drv_sel = 1'b0;
        #1 chk("abort LO", HLOut, 32'd0);
        drv_sel = 1'b1;
        #1 chk("abort HI", HLOut, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk); #3 reset = 1'b1;

        run_op("mul after reset", 32'd6, 32'd7, 0, 0, 0, 0,
               32'd0, 32'd42, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
